// File: rtl/sys_timer_responder.sv
// Sys-port register window: prescaled 32-bit timer with compare match, overflow flag and irq,
// plus a scratch register and a read-only ID.
module sys_timer_responder #(
  parameter logic [31:0] BASE     = 32'h0000_1000,
  parameter logic [31:0] ID_VALUE = 32'h5449_4D31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sys_r_addr,
  input  logic        sys_read,
  output logic [31:0] sys_r_line,
  input  logic [31:0] sys_w_addr,
  input  logic        sys_write,
  input  logic [31:0] sys_w_line,
  output logic        irq
);

  logic        en_q, en_d;
  logic        reload_q, reload_d;
  logic        irq_en_q, irq_en_d;
  logic [7:0]  presc_q, presc_d;
  logic [7:0]  pdiv_q, pdiv_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        match_q, match_d;
  logic        ovf_q, ovf_d;
  logic [31:0] scratch_q, scratch_d;

  logic        r_hit, w_hit, tick, match_set, ovf_set;
  logic [2:0]  r_off, w_off;
  logic [31:0] rdata;
  logic        unused_addr;

  assign unused_addr = ^{sys_r_addr[1:0], sys_w_addr[1:0]};

  assign r_hit = sys_r_addr[31:5] == BASE[31:5];
  assign w_hit = sys_write && (sys_w_addr[31:5] == BASE[31:5]);
  assign r_off = sys_r_addr[4:2];
  assign w_off = sys_w_addr[4:2];
  assign tick  = en_q && (pdiv_q == presc_q);
  assign irq   = irq_en_q & match_q;

  always_comb begin
    rdata = '0;
    case (r_off)
      3'd0:    rdata = {16'h0, presc_q, 5'h0, irq_en_q, reload_q, en_q};
      3'd1:    rdata = count_q;
      3'd2:    rdata = compare_q;
      3'd3:    rdata = {30'h0, ovf_q, match_q};
      3'd4:    rdata = scratch_q;
      3'd5:    rdata = ID_VALUE;
      default: rdata = '0;
    endcase
    sys_r_line = (sys_read && r_hit) ? rdata : '0;
  end

  always_comb begin
    en_d      = en_q;
    reload_d  = reload_q;
    irq_en_d  = irq_en_q;
    presc_d   = presc_q;
    compare_d = compare_q;
    scratch_d = scratch_q;
    count_d   = count_q;
    match_set = 1'b0;
    ovf_set   = 1'b0;

    if (tick) begin
      if (count_q == compare_q) begin
        match_set = 1'b1;
        count_d   = reload_q ? 32'h0 : count_q + 32'd1;
      end else if (count_q == 32'hFFFF_FFFF) begin
        ovf_set = 1'b1;
        count_d = 32'h0;
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    match_d = match_q | match_set;
    ovf_d   = ovf_q | ovf_set;

    // Software writes override the tick result; hardware flag sets beat W1C.
    if (w_hit) begin
      case (w_off)
        3'd0: begin
          en_d     = sys_w_line[0];
          reload_d = sys_w_line[1];
          irq_en_d = sys_w_line[2];
          presc_d  = sys_w_line[15:8];
        end
        3'd1: count_d = sys_w_line;
        3'd2: compare_d = sys_w_line;
        3'd3: begin
          match_d = (match_q & ~sys_w_line[0]) | match_set;
          ovf_d   = (ovf_q & ~sys_w_line[1]) | ovf_set;
        end
        3'd4: scratch_d = sys_w_line;
        default: ;
      endcase
    end

    // pdiv stays 0 while disabled and is cleared in the cycle EN is written low.
    if (!en_q || !en_d) begin
      pdiv_d = 8'h0;
    end else if (tick) begin
      pdiv_d = 8'h0;
    end else begin
      pdiv_d = pdiv_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q      <= 1'b0;
      reload_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      presc_q   <= 8'h0;
      pdiv_q    <= 8'h0;
      count_q   <= 32'h0;
      compare_q <= 32'hFFFF_FFFF;
      match_q   <= 1'b0;
      ovf_q     <= 1'b0;
      scratch_q <= 32'h0;
    end else begin
      en_q      <= en_d;
      reload_q  <= reload_d;
      irq_en_q  <= irq_en_d;
      presc_q   <= presc_d;
      pdiv_q    <= pdiv_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
      ovf_q     <= ovf_d;
      scratch_q <= scratch_d;
    end
  end

endmodule

// File: tb/tb_sys_timer_responder.sv
// Scoreboard bench for sys_timer_responder: each bus cycle queues its expected read data,
// which is popped and compared once the combinational read settles.
module tb_sys_timer_responder;

  localparam logic [31:0] Base    = 32'h0000_1000;
  localparam logic [31:0] IdValue = 32'h5449_4D31;
  localparam logic [31:0] ACtrl   = Base + 32'h00;
  localparam logic [31:0] ACount  = Base + 32'h04;
  localparam logic [31:0] ACmp    = Base + 32'h08;
  localparam logic [31:0] AStat   = Base + 32'h0C;
  localparam logic [31:0] AScr    = Base + 32'h10;
  localparam logic [31:0] AId     = Base + 32'h14;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] sys_r_addr = '0;
  logic        sys_read = 1'b0;
  logic [31:0] sys_r_line;
  logic [31:0] sys_w_addr = '0;
  logic        sys_write = 1'b0;
  logic [31:0] sys_w_line = '0;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  sys_timer_responder #(
    .BASE    (Base),
    .ID_VALUE(IdValue)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sys_r_addr(sys_r_addr),
    .sys_read  (sys_read),
    .sys_r_line(sys_r_line),
    .sys_w_addr(sys_w_addr),
    .sys_write (sys_write),
    .sys_w_line(sys_w_line),
    .irq       (irq)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive at negedge, compare read data mid-cycle, commit at the next posedge.
  task automatic xfer(input bit do_rd, input logic [31:0] ra, input logic [31:0] exp,
                      input bit do_wr, input logic [31:0] wa, input logic [31:0] wd,
                      input string tag, input int exp_irq);
    logic [31:0] e;
    string       t;
    @(negedge clk);
    sys_read   = do_rd;
    sys_r_addr = ra;
    sys_write  = do_wr;
    sys_w_addr = wa;
    sys_w_line = wd;
    if (do_rd) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    #2;
    if (do_rd) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, sys_r_line, e);
    end
    if (exp_irq >= 0) check_eq({tag, "_irq"}, {31'h0, irq}, exp_irq[31:0]);
    @(posedge clk);
    #1;
    sys_read  = 1'b0;
    sys_write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp,
                    input int ei = -1);
    xfer(1'b1, a, exp, 1'b0, '0, '0, tag, ei);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    xfer(1'b0, '0, '0, 1'b1, a, d, "wr", -1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    // Reset and ID
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    rd("id", AId, IdValue, 0);
    rd("ctrl_rst", ACtrl, 32'h0);
    rd("stat_rst", AStat, 32'h0);
    rd("cmp_rst", ACmp, 32'hFFFF_FFFF);
    rd("count_rst", ACount, 32'h0, 0);

    // Prescale 3: COUNT advances exactly every 4 cycles
    wr(ACtrl, 32'h0000_0301);
    for (int i = 0; i <= 40; i++) rd($sformatf("count_p%0d", i), ACount, 32'(i / 4));

    // Compare, reload, irq, W1C and W1C collision
    do_reset();
    wr(ACmp, 32'd5);
    wr(ACtrl, 32'h7);
    for (int i = 0; i < 8; i++)
      rd($sformatf("cmp_count%0d", i), ACount, (i <= 5) ? 32'(i) : 32'(i - 6), (i >= 6) ? 1 : 0);
    rd("match_set", AStat, 32'h1, 1);
    wr(AStat, 32'h1);
    rd("match_clr", AStat, 32'h0, 0);
    wr(AStat, 32'h1);
    rd("w1c_collide", AStat, 32'h1, 1);
    rd("reload_count", ACount, 32'h1);

    // Overflow, then tick-cycle COUNT write, then disable holds COUNT
    do_reset();
    wr(ACount, 32'hFFFF_FFFE);
    wr(ACmp, 32'h0);
    wr(ACtrl, 32'h1);
    rd("ovf_c0", ACount, 32'hFFFF_FFFE);
    rd("ovf_c1", ACount, 32'hFFFF_FFFF);
    rd("ovf_flag", AStat, 32'h2, 0);
    rd("ovf_match", AStat, 32'h3, 0);
    rd("ovf_c4", ACount, 32'h2);
    wr(ACount, 32'd100);
    rd("tick_wr", ACount, 32'd100);
    wr(ACtrl, 32'h0);
    rd("hold0", ACount, 32'd102);
    rd("hold1", ACount, 32'd102);

    // Same-cycle read and write of SCRATCH
    wr(AScr, 32'hA5);
    xfer(1'b1, AScr, 32'hA5, 1'b1, AScr, 32'h5A, "scr_rw", -1);
    rd("scr_new", AScr, 32'h5A);

    // Decode misses, reserved offsets, ignored byte bits, strobe gating
    rd("miss_hi", Base + 32'h20, 32'h0);
    rd("miss_lo", Base - 32'h4, 32'h0);
    rd("rsvd18", Base + 32'h18, 32'h0);
    rd("rsvd1c", Base + 32'h1C, 32'h0);
    rd("id_byte", Base + 32'h17, IdValue);
    @(negedge clk);
    sys_r_addr = AId;
    sys_read   = 1'b0;
    #2 check_eq("no_strobe", sys_r_line, 32'h0);
    wr(Base + 32'h20, 32'hFFFF_FFFF);
    wr(Base + 32'h30, 32'hFFFF_FFFF);
    wr(Base - 32'h4, 32'hFFFF_FFFF);
    wr(Base + 32'h18, 32'hFFFF_FFFF);
    wr(AId, 32'h0);
    rd("miss_ctrl", ACtrl, 32'h0);
    rd("miss_scr", AScr, 32'h5A);
    rd("miss_count", ACount, 32'd102);
    rd("miss_cmp", ACmp, 32'h0);
    rd("id_ro", AId, IdValue);
    wr(ACtrl, 32'hFFFF_FFFF);
    rd("ctrl_mask", ACtrl, 32'h0000_FF07);

    // Mid-count asynchronous reset, checked before any clock edge
    wr(ACtrl, 32'h7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    sys_read = 1'b1;
    sys_r_addr = ACtrl;   #1 check_eq("arst_ctrl", sys_r_line, 32'h0);
    sys_r_addr = ACount;  #1 check_eq("arst_count", sys_r_line, 32'h0);
    sys_r_addr = ACmp;    #1 check_eq("arst_cmp", sys_r_line, 32'hFFFF_FFFF);
    sys_r_addr = AStat;   #1 check_eq("arst_stat", sys_r_line, 32'h0);
    sys_r_addr = AScr;    #1 check_eq("arst_scr", sys_r_line, 32'h0);
    check_eq("arst_irq", {31'h0, irq}, 32'h0);
    #1 rst = 1'b1;
    sys_read = 1'b0;
    repeat (5) @(posedge clk);
    rd("no_restart", ACount, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
